// File: rtl/fifo_reader.sv
// Two-entry skid reader: pops an upstream fifo into a head/skid buffer and presents a valid/ready stream.
// Pop-to-valid latency 1 cycle; pop never depends on i_ready, so the skid slot absorbs a stalled sink.
module fifo_reader #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cg,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_fifo_data,
    input  logic             i_fifo_empty,
    output logic             o_fifo_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready,
    output logic [1:0]       o_occupancy,
    output logic [15:0]      o_count
);

    logic [1:0]       occ_q,  occ_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic [15:0]      cnt_q,  cnt_d;

    logic             pop;
    logic             xfer;
    logic [1:0]       wr_idx;

    assign pop    = i_cg & ~i_rst & ~i_flush & ~i_fifo_empty & (occ_q != 2'd2);
    assign xfer   = valid_q & i_ready & i_cg;
    // Slot the popped word lands in, after the head has possibly left this cycle.
    assign wr_idx = occ_q - {1'b0, xfer};

    always_comb begin
        occ_d   = occ_q;
        valid_d = valid_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        cnt_d   = cnt_q;
        if (i_cg) begin
            cnt_d = cnt_q + {15'd0, xfer};
            if (i_flush) begin
                occ_d = 2'd0;
            end else begin
                occ_d = occ_q + {1'b0, pop} - {1'b0, xfer};
                if (xfer && (occ_q == 2'd2)) begin
                    ent0_d = ent1_q;
                end
                if (pop) begin
                    if (wr_idx == 2'd0) begin
                        ent0_d = i_fifo_data;
                    end else begin
                        ent1_d = i_fifo_data;
                    end
                end
            end
            valid_d = (occ_d != 2'd0);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
            ent0_q  <= '0;
            ent1_q  <= '0;
            cnt_q   <= 16'd0;
        end else begin
            occ_q   <= occ_d;
            valid_q <= valid_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_fifo_pop  = pop;
    assign o_valid     = valid_q;
    assign o_data      = ent0_q;
    assign o_occupancy = occ_q;
    assign o_count     = cnt_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Randomised and directed checks of fifo_reader against a queue-based reference of the buffer.
module tb_fifo_reader;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst, cg, flush, fifo_empty, ready;
    logic [W-1:0]  fifo_data;
    logic          fifo_pop, valid;
    logic [W-1:0]  data;
    logic [1:0]    occ;
    logic [15:0]   cnt;

    always #5 clk = ~clk;

    fifo_reader #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cg         (cg),
        .i_flush      (flush),
        .i_fifo_data  (fifo_data),
        .i_fifo_empty (fifo_empty),
        .o_fifo_pop   (fifo_pop),
        .o_valid      (valid),
        .o_data       (data),
        .i_ready      (ready),
        .o_occupancy  (occ),
        .o_count      (cnt)
    );

    logic [W-1:0] up_q[$];
    logic [W-1:0] m_buf[$];
    int           m_cnt;
    int           n_chk = 0;
    int           n_bad = 0;
    int           snap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_pop();
        return cg && !rst && !flush && (up_q.size() > 0) && (m_buf.size() < 2);
    endfunction

    task automatic model_update();
        bit p, x;
        p = exp_pop();
        x = cg && !rst && (m_buf.size() > 0) && ready;
        if (rst) begin
            m_buf.delete();
            m_cnt = 0;
        end else if (cg) begin
            if (x) begin
                void'(m_buf.pop_front());
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (flush) m_buf.delete();
            else if (p) m_buf.push_back(up_q.pop_front());
        end
    endtask

    // Called just after a falling edge with the control inputs already set.
    task automatic cycle();
        fifo_empty = (up_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : up_q[0];
        #1;
        check("pop",   32'(fifo_pop), 32'(exp_pop()));
        check("valid", 32'(valid),    32'(m_buf.size() != 0));
        check("occ",   32'(occ),      32'(m_buf.size()));
        check("count", 32'(cnt),      32'(m_cnt));
        if (m_buf.size() != 0) check("data", 32'(data), 32'(m_buf[0]));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; cg = 1'b1; flush = 1'b0; ready = 1'b0;
        fifo_empty = 1'b1; fifo_data = '0; m_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        up_q.push_back(8'h11); up_q.push_back(8'h22); up_q.push_back(8'h33);
        fifo_empty = 1'b0; fifo_data = 8'h11;
        #1;
        check("rst_valid", 32'(valid),    32'd0);
        check("rst_occ",   32'(occ),      32'd0);
        check("rst_data",  32'(data),     32'd0);
        check("rst_count", 32'(cnt),      32'd0);
        check("rst_pop",   32'(fifo_pop), 32'd0);
        @(negedge clk);

        // Three-word stream at full rate
        rst = 1'b0; ready = 1'b1;
        repeat (5) cycle();
        check("s1_count", 32'(cnt), 32'd3);

        // Stalled sink fills both slots
        ready = 1'b0;
        for (int i = 0; i < 4; i++) up_q.push_back(8'h40 + 8'(i));
        repeat (4) cycle();
        check("s2_occ",  32'(occ),      32'd2);
        check("s2_pop",  32'(fifo_pop), 32'd0);
        check("s2_data", 32'(data),     32'h40);
        ready = 1'b1;
        repeat (5) cycle();

        // Flush with a full buffer and a concurrent transfer
        ready = 1'b0;
        up_q.push_back(8'hA0); up_q.push_back(8'hA1);
        repeat (3) cycle();
        check("s3_occ_full", 32'(occ), 32'd2);
        snap = m_cnt;
        flush = 1'b1; ready = 1'b1;
        cycle();
        flush = 1'b0;
        check("s3_occ",   32'(occ), 32'd0);
        check("s3_count", 32'(cnt), 32'((snap + 1) % 65536));
        repeat (2) cycle();

        // Clock gate held low mid-stream
        for (int i = 0; i < 8; i++) up_q.push_back(8'h60 + 8'(i));
        repeat (2) cycle();
        cg = 1'b0;
        repeat (4) cycle();
        cg = 1'b1;
        repeat (9) cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2, 0) == 0) up_q.push_back(8'($urandom));
            ready = ($urandom_range(3, 0) != 0);
            cg    = ($urandom_range(7, 0) != 0);
            flush = ($urandom_range(31, 0) == 0);
            cycle();
        end
        cg = 1'b1; flush = 1'b0;

        // Asynchronous reset with the buffer full
        ready = 1'b0;
        for (int i = 0; i < 4; i++) up_q.push_back(8'h80 + 8'(i));
        repeat (3) cycle();
        check("s6_occ_full", 32'(occ), 32'd2);
        #3 rst = 1'b1;
        m_buf.delete();
        m_cnt = 0;
        #1;
        check("s6_valid", 32'(valid),    32'd0);
        check("s6_occ",   32'(occ),      32'd0);
        check("s6_count", 32'(cnt),      32'd0);
        check("s6_pop",   32'(fifo_pop), 32'd0);
        @(posedge clk);
        model_update();
        @(negedge clk);
        cycle();
        rst = 1'b0;
        ready = 1'b1;
        cycle();

        // Counter wrap
        for (int i = 0; i < 70000 && m_cnt != 65535; i++) begin
            if (up_q.size() < 3) up_q.push_back(8'($urandom));
            cycle();
        end
        check("wrap_ffff", 32'(cnt), 32'hFFFF);
        if (up_q.size() < 3) up_q.push_back(8'($urandom));
        cycle();
        check("wrap_zero", 32'(cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width in bits (minimum 1).
REQ-002 SHALL have port i_clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port i_cg  input  1  clock-gate enable, active-high; when low all state holds.
REQ-005 SHALL have port i_flush  input  1  synchronous clear of buffered entries.
REQ-006 SHALL have port i_fifo_data  input  WIDTH  head entry of the upstream fifo, valid whenever i_fifo_empty is low.
REQ-007 SHALL have port i_fifo_empty  input  1  upstream fifo empty flag.
REQ-008 SHALL have port o_fifo_pop  output  1  pop strobe to the upstream fifo.
REQ-009 SHALL have port o_valid  output  1  downstream data valid.
REQ-010 SHALL have port o_data  output  WIDTH  downstream data.
REQ-011 SHALL have port i_ready  input  1  downstream ready.
REQ-012 SHALL have port o_occupancy  output  2  number of buffered entries (0..2).
REQ-013 SHALL have port o_count  output  16  number of completed downstream transfers.

Function
REQ-014 SHALL hold a 2-entry in-order buffer: entry0 (head, drives o_data) and entry1 (skid).
REQ-015 SHALL drive o_fifo_pop = i_cg & !i_rst & !i_flush & !i_fifo_empty & (occupancy < 2). It has no combinational dependence on i_ready.
REQ-016 SHALL drive o_valid = (occupancy != 0). It is a registered signal.
REQ-017 SHALL define a transfer as o_valid & i_ready & i_cg in the same cycle.
REQ-018 SHALL update occupancy each cycle as occupancy + pop - transfer. Result is always within 0..2.
REQ-019 SHALL write the popped word to entry[occupancy - transfer]. This applies to the pre-update occupancy.
REQ-020 SHALL move entry1 to entry0 on a transfer when occupancy is 2.
REQ-021 SHALL support simultaneous pop and transfer at occupancy 1. Entry0 takes the new word and occupancy stays 1.
REQ-022 SHALL support simultaneous pop and transfer at occupancy 0 only as a pop. No transfer is possible because o_valid is low.
REQ-023 SHALL give latency from pop to o_valid of exactly 1 cycle when the buffer is empty.
REQ-024 SHALL sustain 1 word/cycle throughput while i_ready stays high and the upstream fifo is non-empty.
REQ-025 SHALL preserve upstream order exactly. No word is duplicated or dropped except by flush.
REQ-026 SHALL handle i_flush high with i_cg high as follows: next occupancy is 0, no pop, and buffered data is discarded. A transfer in the same cycle still increments o_count.
REQ-027 SHALL increment o_count by 1 on each transfer, wrapping from 0xFFFF to 0x0000. Flush does not clear it.
REQ-028 SHALL, while i_cg is low, hold all registers and keep o_fifo_pop low. Any transfer is ignored and o_count is unchanged.
REQ-029 SHALL keep o_data stable while o_valid is high and i_ready is low.

Reset
REQ-030 SHALL, while i_rst is high, force occupancy=0, o_valid=0, o_data=0, o_count=0, and both entries to 0 asynchronously.
REQ-031 SHALL keep o_fifo_pop low throughout reset.
REQ-032 SHALL, when i_rst is asserted mid-operation, discard buffered entries. The upstream fifo is not popped.
REQ-033 SHALL allow the first pop on the first rising edge after i_rst deasserts, provided i_fifo_empty is low.

Verification
REQ-034 SHALL pass this scenario. Stimulus: after reset, upstream holds 0x11,0x22,0x33 and i_ready=1 constantly. Response: o_fifo_pop is high for 3 cycles; o_data shows 0x11,0x22,0x33 on consecutive cycles, starting 1 cycle after the first pop; o_count=3.
REQ-035 SHALL pass this scenario. Stimulus: i_ready=0 and upstream is non-empty. Response: exactly 2 pops occur, occupancy=2, o_fifo_pop stays low and o_data=first word stable. On releasing i_ready both words emerge in order.
REQ-036 SHALL pass this scenario. Stimulus: occupancy=2 with entries 0xA0,0xA1; assert i_flush with i_ready=1 for one cycle. Response: o_count increments by 1, occupancy=0 next cycle, and 0xA1 is never output.
REQ-037 SHALL pass this scenario. Stimulus: hold i_cg=0 for 4 cycles mid-stream with i_ready=1. Response: no pops, occupancy/o_data/o_count frozen, and the stream resumes unchanged afterwards.
REQ-038 SHALL pass this scenario. Stimulus: preset 0xFFFF transfers, then one more transfer. Response: o_count=0x0000.
REQ-039 SHALL pass this scenario. Stimulus: assert i_rst asynchronously between edges with occupancy=2. Response: o_valid=0 and occupancy=0 immediately, and o_fifo_pop stays low until reset is released.
